// File: rtl/mac_array_sequencer_if.sv
// mac_array_sequencer_if: control, operand-read and result-write signals of the sequencer
interface mac_array_sequencer_if #(
    parameter int ROW   = 8,
    parameter int COL   = 4,
    parameter int WIDTH = 10
);
    localparam int RW = ($clog2(ROW) > 1) ? $clog2(ROW) : 1;
    localparam int CW = ($clog2(COL) > 1) ? $clog2(COL) : 1;
    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic             rd_en;
    logic [RW-1:0]    rd_row;
    logic [CW-1:0]    rd_col;
    logic [WIDTH-1:0] a_data;
    logic [WIDTH-1:0] b_data;
    logic             wr_en;
    logic [RW-1:0]    wr_row;
    logic [CW-1:0]    wr_col;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ready;
    modport master (
        input  start, abort, a_data, b_data, wr_ready,
        output busy, done, rd_en, rd_row, rd_col, wr_en, wr_row, wr_col, wr_data
    );
    modport slave (
        output start, abort, a_data, b_data, wr_ready,
        input  busy, done, rd_en, rd_row, rd_col, wr_en, wr_row, wr_col, wr_data
    );
endinterface

// File: rtl/mac_array_sequencer.sv
// mac_array_sequencer: row-major sweep of two operand stores writing a[i][j]*b[j][i] per element
module mac_array_sequencer #(
    parameter int ROW   = 8,
    parameter int COL   = 4,
    parameter int WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mac_array_sequencer_if.master bus
);
    localparam int RW = ($clog2(ROW) > 1) ? $clog2(ROW) : 1;
    localparam int CW = ($clog2(COL) > 1) ? $clog2(COL) : 1;
    localparam logic [RW-1:0] row_last = RW'(ROW - 1);
    localparam logic [CW-1:0] col_last = CW'(COL - 1);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nxt;
    logic [RW-1:0]    row_q, ret_row, skid_row, wr_row_q, src_row;
    logic [CW-1:0]    col_q, ret_col, skid_col, wr_col_q, src_col;
    logic [WIDTH-1:0] skid_a, skid_b, wr_data_q, src_a, src_b, prod;
    logic             ret_v, skid_v, wr_v, done_q;
    logic             rd, wr_free, wr_xfer, last_rd, last_wr, load;
    always_comb begin
        wr_xfer   = wr_v && bus.wr_ready;
        wr_free   = !wr_v || bus.wr_ready;
        rd        = state == RUN && !bus.abort && !skid_v && wr_free;
        last_rd   = rd && row_q == row_last && col_q == col_last;
        last_wr   = wr_xfer && wr_row_q == row_last && wr_col_q == col_last;
        load      = (skid_v || ret_v) && wr_free;
        src_a     = skid_v ? skid_a : bus.a_data;
        src_b     = skid_v ? skid_b : bus.b_data;
        src_row   = skid_v ? skid_row : ret_row;
        src_col   = skid_v ? skid_col : ret_col;
        prod      = src_a * src_b;
        state_nxt = bus.abort                   ? IDLE  :
                    state == IDLE && bus.start  ? RUN   :
                    state == RUN && last_rd     ? DRAIN :
                    state == DRAIN && last_wr   ? IDLE  : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    // The skid only ever fills while the write stage stalls, so it and the return slot are never both live.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q     <= '0;
            col_q     <= '0;
            ret_v     <= 1'b0;
            ret_row   <= '0;
            ret_col   <= '0;
            skid_v    <= 1'b0;
            skid_a    <= '0;
            skid_b    <= '0;
            skid_row  <= '0;
            skid_col  <= '0;
            wr_v      <= 1'b0;
            wr_row_q  <= '0;
            wr_col_q  <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else if (bus.abort) begin
            row_q  <= '0;
            col_q  <= '0;
            ret_v  <= 1'b0;
            skid_v <= 1'b0;
            wr_v   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q  <= state == DRAIN && last_wr;
            ret_v   <= rd;
            ret_row <= row_q;
            ret_col <= col_q;
            if (rd) begin
                col_q <= col_q == col_last ? '0 : col_q + 1'b1;
                if (col_q == col_last)
                    row_q <= row_q == row_last ? '0 : row_q + 1'b1;
            end
            if (load) begin
                wr_v      <= 1'b1;
                wr_row_q  <= src_row;
                wr_col_q  <= src_col;
                wr_data_q <= prod;
            end else if (wr_xfer) begin
                wr_v <= 1'b0;
            end
            if (ret_v && !wr_free) begin
                skid_v   <= 1'b1;
                skid_a   <= bus.a_data;
                skid_b   <= bus.b_data;
                skid_row <= ret_row;
                skid_col <= ret_col;
            end else if (skid_v && wr_free) begin
                skid_v <= 1'b0;
            end
        end
    end
    assign bus.busy    = state != IDLE;
    assign bus.done    = done_q;
    assign bus.rd_en   = rd;
    assign bus.rd_row  = row_q;
    assign bus.rd_col  = col_q;
    assign bus.wr_en   = wr_v;
    assign bus.wr_row  = wr_row_q;
    assign bus.wr_col  = wr_col_q;
    assign bus.wr_data = wr_data_q;
endmodule

// File: tb/tb_mac_array_sequencer.sv
// tb_mac_array_sequencer: directed passes checked every cycle against a row-major product model
module tb_mac_array_sequencer;
    localparam int ROW = 8, COL = 4, WIDTH = 10, N = ROW * COL;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_array_sequencer_if #(.ROW(ROW), .COL(COL), .WIDTH(WIDTH)) bus ();
    mac_array_sequencer_if #(.ROW(1), .COL(1), .WIDTH(WIDTH)) bus1 ();
    mac_array_sequencer #(.ROW(ROW), .COL(COL), .WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    mac_array_sequencer #(.ROW(1), .COL(1), .WIDTH(WIDTH)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int tests = 0, fails = 0;
    int a_mem [ROW][COL];
    int b_mem [COL][ROW];
    int obs_data [N];
    int cyc = 0, first_rd = -1, first_wr = -1, obs_xfers = 0, obs_done = 0;
    int rd_cnt = 0, wr_cnt = 0;
    bit m_busy = 0, m_done = 0, prev_stall = 0, fin, nb;
    logic [WIDTH-1:0] prev_data;
    logic [2:0] prev_row;
    logic [1:0] prev_col;
    bit mem_pend;
    int mem_r, mem_c;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill(input int kind);
        for (int i = 0; i < ROW; i++)
            for (int j = 0; j < COL; j++) begin
                a_mem[i][j] = kind == 0 ? i * 4 + j + 1 : kind == 1 ? 1023 : int'($urandom_range(0, 1023));
                b_mem[j][i] = kind == 0 ? 3 : kind == 1 ? 1023 : int'($urandom_range(0, 1023));
            end
    endtask

    // mode 0: ready always; 1: random ready plus a start while busy; 2: ready low 5 cycles at first write
    task automatic run_pass(input int mode, input int abort_at);
        int rds = 0;
        int stall = 0;
        bit seen = 0;
        obs_xfers = 0;
        obs_done = 0;
        first_rd = -1;
        first_wr = -1;
        bus.wr_ready = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (mode == 1) begin
                bus.wr_ready = 1'($urandom_range(0, 1));
                bus.start = n == 10;
            end
            if (mode == 2) begin
                if (!seen && bus.wr_en) begin
                    seen = 1;
                    stall = 5;
                end
                bus.wr_ready = stall == 0;
                if (stall > 0) stall--;
            end
            if (abort_at > 0 && bus.rd_en) begin
                rds++;
                if (rds == abort_at) begin
                    bus.abort = 1'b1;
                    @(posedge clk);
                    #1;
                    bus.abort = 1'b0;
                    return;
                end
            end
            if (bus.done) begin
                bus.wr_ready = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
        chk("pass_timeout", bus.done, 1);
        bus.wr_ready = 1'b1;
    endtask

    always @(negedge clk) begin
        mem_pend = bus.rd_en;
        mem_r = int'(bus.rd_row);
        mem_c = int'(bus.rd_col);
        @(posedge clk);
        #1;
        bus.a_data = mem_pend ? WIDTH'(a_mem[mem_r][mem_c]) : WIDTH'($urandom);
        bus.b_data = mem_pend ? WIDTH'(b_mem[mem_c][mem_r]) : WIDTH'($urandom);
    end

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_rd_en", bus.rd_en, 0);
            chk("rst_wr_en", bus.wr_en, 0);
            chk("rst_rd_idx", {bus.rd_row, bus.rd_col}, 0);
            chk("rst_wr_idx", {bus.wr_row, bus.wr_col}, 0);
            chk("rst_wr_data", bus.wr_data, 0);
            m_busy = 0; m_done = 0; prev_stall = 0; rd_cnt = 0; wr_cnt = 0;
        end else if (bus.abort) begin
            if (bus.done) obs_done++;
            m_busy = 0; m_done = 0; prev_stall = 0; rd_cnt = 0; wr_cnt = 0;
        end else begin
            fin = 0;
            chk("busy", bus.busy, m_busy);
            chk("done", bus.done, m_done);
            if (bus.done) obs_done++;
            if (!m_busy) begin
                chk("idle_rd_en", bus.rd_en, 0);
                chk("idle_wr_en", bus.wr_en, 0);
            end
            if (bus.rd_en) chk("rd_gate", bus.wr_en && !bus.wr_ready, 0);
            if (m_busy && bus.rd_en) begin
                chk("rd_row", bus.rd_row, rd_cnt / COL);
                chk("rd_col", bus.rd_col, rd_cnt % COL);
                if (first_rd < 0) first_rd = cyc;
                rd_cnt++;
            end
            if (prev_stall) begin
                chk("hold_en", bus.wr_en, 1);
                chk("hold_row", bus.wr_row, prev_row);
                chk("hold_col", bus.wr_col, prev_col);
                chk("hold_data", bus.wr_data, prev_data);
            end
            if (m_busy && bus.wr_en && bus.wr_ready) begin
                chk("wr_row", bus.wr_row, wr_cnt / COL);
                chk("wr_col", bus.wr_col, wr_cnt % COL);
                chk("wr_data", bus.wr_data,
                    (a_mem[(wr_cnt % N) / COL][wr_cnt % COL] * b_mem[wr_cnt % COL][(wr_cnt % N) / COL]) % (1 << WIDTH));
                if (obs_xfers < N) obs_data[obs_xfers] = int'(bus.wr_data);
                if (first_wr < 0) first_wr = cyc;
                obs_xfers++;
                wr_cnt++;
                fin = wr_cnt == N;
            end
            prev_stall = bus.wr_en && !bus.wr_ready;
            prev_row = bus.wr_row;
            prev_col = bus.wr_col;
            prev_data = bus.wr_data;
            nb = m_busy ? !fin : bus.start;
            if (!m_busy && bus.start) begin
                rd_cnt = 0;
                wr_cnt = 0;
            end
            m_busy = nb;
            m_done = fin;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, %0d tests run", tests);
        $fatal(1);
    end

    initial begin
        bus.start = 0; bus.abort = 0; bus.wr_ready = 1;
        bus1.start = 0; bus1.abort = 0; bus1.wr_ready = 1; bus1.a_data = 5; bus1.b_data = 7;
        repeat (3) @(posedge clk);
        #1;
        chk("rst1_busy", bus1.busy, 0);
        chk("rst1_wr_en", bus1.wr_en, 0);
        rst_n = 1'b1;
        idle(1);

        fill(0);
        run_pass(0, 0);
        idle(3);
        chk("p1_xfers", obs_xfers, 32);
        chk("p1_done_cnt", obs_done, 1);
        chk("p1_latency", first_wr - first_rd, 2);
        chk("p1_w00", obs_data[0], 3);
        chk("p1_w01", obs_data[1], 6);
        chk("p1_w10", obs_data[4], 15);
        chk("p1_w73", obs_data[31], 96);

        fill(1);
        run_pass(0, 0);
        idle(2);
        chk("p2_w00", obs_data[0], 1);
        chk("p2_w73", obs_data[31], 1);
        chk("p2_xfers", obs_xfers, 32);

        fill(2);
        run_pass(2, 0);
        idle(3);
        chk("p3_xfers", obs_xfers, 32);
        chk("p3_done_cnt", obs_done, 1);

        fill(2);
        run_pass(1, 0);
        idle(3);
        chk("p4_xfers", obs_xfers, 32);
        chk("p4_done_cnt", obs_done, 1);

        fill(2);
        run_pass(0, 5);
        chk("ab_busy", bus.busy, 0);
        chk("ab_wr_en", bus.wr_en, 0);
        idle(4);
        chk("ab_done_cnt", obs_done, 0);

        fill(0);
        run_pass(0, 0);
        idle(2);
        chk("p6_w00", obs_data[0], 3);
        chk("p6_xfers", obs_xfers, 32);

        bus.start = 1'b1;
        bus.abort = 1'b1;
        idle(1);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("sa_busy", bus.busy, 0);
        idle(2);
        chk("sa_busy_late", bus.busy, 0);

        fill(2);
        obs_done = 0;
        bus.start = 1'b1;
        idle(1);
        bus.start = 1'b0;
        repeat (12) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_rd_en", bus.rd_en, 0);
        chk("arst_wr_en", bus.wr_en, 0);
        chk("arst_wr_data", bus.wr_data, 0);
        chk("arst_idx", {bus.rd_row, bus.rd_col, bus.wr_row, bus.wr_col}, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle(2);
        chk("arst_done_cnt", obs_done, 0);
        run_pass(0, 0);
        idle(3);
        chk("p8_xfers", obs_xfers, 32);
        chk("p8_done_cnt", obs_done, 1);

        bus1.start = 1'b1;
        idle(1);
        bus1.start = 1'b0;
        chk("s1_busy", bus1.busy, 1);
        chk("s1_rd_en", bus1.rd_en, 1);
        chk("s1_rd_idx", {bus1.rd_row, bus1.rd_col}, 0);
        idle(1);
        chk("s1_rd_off", bus1.rd_en, 0);
        chk("s1_wr_early", bus1.wr_en, 0);
        idle(1);
        chk("s1_wr_en", bus1.wr_en, 1);
        chk("s1_wr_data", bus1.wr_data, 35);
        idle(1);
        chk("s1_done", bus1.done, 1);
        chk("s1_busy_end", bus1.busy, 0);
        chk("s1_wr_end", bus1.wr_en, 0);
        idle(1);
        chk("s1_done_end", bus1.done, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
